// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin, burst-locking arbiter for a shared FiFo push port
//
// Purpose: lets REQ_COUNT producers share the write side of one FiFo. A granted
//          requester keeps the FiFo until it sends a LAST beat or MAX_BURST beats.
//          Each accepted beat is tagged with the requester id. It then passes through a
//          one-entry registered stage that drives the FiFo pins directly.
// Ports:
//   CLK, nCLR    clock (rising edge), asynchronous active-low reset
//   REQ_VALID    per-requester beat valid
//   REQ_LAST     per-requester last beat of burst
//   REQ_DATA     requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_READY    per-requester beat accepted this cycle
//   FIFO_nWE     FiFo write enable, active-low
//   FIFO_DIN     {id, data} to FiFo
//   FIFO_FULL    FiFo full flag
//   GRANT_VALID  a requester holds the grant
//   GRANT_ID     current grantee
//   BUSY         grant held or output stage occupied
module fifo_push_arbiter #(
   parameter  int REQ_COUNT  = 4,
   parameter  int DATA_WIDTH = 32,
   parameter  int MAX_BURST  = 8,
   localparam int ID_WIDTH   = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
   input  logic                           CLK,
   input  logic                           nCLR,
   input  logic [REQ_COUNT-1:0]           REQ_VALID,
   input  logic [REQ_COUNT-1:0]           REQ_LAST,
   input  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_DATA,
   output logic [REQ_COUNT-1:0]           REQ_READY,
   output logic                           FIFO_nWE,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] FIFO_DIN,
   input  logic                           FIFO_FULL,
   output logic                           GRANT_VALID,
   output logic [ID_WIDTH-1:0]            GRANT_ID,
   output logic                           BUSY
);

   localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

   typedef enum logic {ST_IDLE, ST_LOCK} state_t;

   state_t                state;
   logic [ID_WIDTH-1:0]   last_id;
   logic [CNT_WIDTH-1:0]  beat_cnt;
   logic [CNT_WIDTH-1:0]  beat_inc;
   logic                  out_valid;

   logic                  rr_found;
   logic [ID_WIDTH-1:0]   rr_winner;
   int                    cand;

   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  can_load;
   logic                  accept;
   logic                  drain;
   logic                  burst_end;

   // Round-robin search starting just after the last releaser, so it becomes lowest priority.
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = '0;
      cand      = 0;
      for (int k = 1; k <= REQ_COUNT; k++) begin
         cand = (int'(last_id) + k) % REQ_COUNT;
         for (int j = 0; j < REQ_COUNT; j++) begin
            if (!rr_found && j == cand && REQ_VALID[j]) begin
               rr_winner = ID_WIDTH'(j);
               rr_found  = 1'b1;
            end
         end
      end
   end

   // Mux the grantee's request lines; compare loop keeps non-power-of-two counts in range.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         if (GRANT_ID == ID_WIDTH'(i)) begin
            sel_valid = REQ_VALID[i];
            sel_last  = REQ_LAST[i];
            sel_data  = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The stage may take a new beat when empty or when it is being written this same cycle.
   assign drain     = out_valid & ~FIFO_FULL;
   assign can_load  = ~out_valid | ~FIFO_FULL;
   assign accept    = (state == ST_LOCK) & sel_valid & can_load;
   assign beat_inc  = beat_cnt + 1'b1;
   assign burst_end = sel_last | (beat_inc == CNT_WIDTH'(MAX_BURST));

   always_comb begin
      REQ_READY = '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         if (state == ST_LOCK && GRANT_ID == ID_WIDTH'(i))
            REQ_READY[i] = sel_valid & can_load;
      end
   end

   assign FIFO_nWE = ~drain;
   assign BUSY     = GRANT_VALID | out_valid;

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         state       <= ST_IDLE;
         GRANT_VALID <= 1'b0;
         GRANT_ID    <= '0;
         last_id     <= ID_WIDTH'(REQ_COUNT - 1);
         beat_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rr_found) begin
                  GRANT_ID    <= rr_winner;
                  GRANT_VALID <= 1'b1;
                  beat_cnt    <= '0;
                  state       <= ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (accept) begin
                  beat_cnt <= beat_inc;
                  if (burst_end) begin
                     state       <= ST_IDLE;
                     GRANT_VALID <= 1'b0;
                     last_id     <= GRANT_ID;
                  end
               end
            end
         endcase
      end
   end

   // Output stage: reload wins over drain so back-to-back beats stream at full rate.
   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         out_valid <= 1'b0;
         FIFO_DIN  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         FIFO_DIN  <= {GRANT_ID, sel_data};
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

   localparam int RC = 4;
   localparam int DW = 32;
   localparam int MB = 8;
   localparam int IW = 2;

   typedef logic [IW+DW-1:0] word_t;
   typedef logic [DW:0]      beat_t;   // {last, data}

   typedef struct {
      int         prev;
      logic [3:0] mask;
      int         win;
   } arb_vec_t;

   logic               CLK = 1'b0;
   logic               nCLR = 1'b1;
   logic [RC-1:0]      REQ_VALID = '0;
   logic [RC-1:0]      REQ_LAST = '0;
   logic [RC*DW-1:0]   REQ_DATA = '0;
   logic [RC-1:0]      REQ_READY;
   logic               FIFO_nWE;
   logic [IW+DW-1:0]   FIFO_DIN;
   logic               FIFO_FULL = 1'b0;
   logic               GRANT_VALID;
   logic [IW-1:0]      GRANT_ID;
   logic               BUSY;

   fifo_push_arbiter #(.REQ_COUNT(RC), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .CLK(CLK), .nCLR(nCLR),
      .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
      .FIFO_nWE(FIFO_nWE), .FIFO_DIN(FIFO_DIN), .FIFO_FULL(FIFO_FULL),
      .GRANT_VALID(GRANT_VALID), .GRANT_ID(GRANT_ID), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   beat_t   rq [RC][$];
   word_t   exp_q[$];
   word_t   pop_exp[$];
   word_t   fifo_m[$];
   int      grant_log[$];
   logic [RC-1:0] acc = '0;
   logic    wr_pending = 1'b0;
   logic    pop_pending = 1'b0;
   logic    prev_gv = 1'b0;
   logic    full_force = 1'b0;
   logic    integ = 1'b0;
   word_t   wr_din = '0;
   int      n_checks = 0;
   int      n_fail = 0;
   int      cyc = 0;
   int      write_cnt = 0;
   int      pop_cnt = 0;
   int      ovf_cnt = 0;

   function automatic word_t mk(input int id, input int d);
      return {IW'(id), DW'(d)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < RC; i++) begin
         beat_t b;
         if (rq[i].size() > 0) begin
            b = rq[i][0];
            REQ_VALID[i] = 1'b1;
            REQ_LAST[i]  = b[DW];
            REQ_DATA[i*DW +: DW] = b[DW-1:0];
         end else begin
            REQ_VALID[i] = 1'b0;
            REQ_LAST[i]  = 1'b0;
            REQ_DATA[i*DW +: DW] = '0;
         end
      end
      FIFO_FULL = integ ? (fifo_m.size() >= 2) : full_force;
   endtask

   // Called on the falling edge: records what the coming rising edge will do.
   task automatic sample();
      acc = REQ_VALID & REQ_READY;
      wr_pending = (FIFO_nWE == 1'b0);
      wr_din = FIFO_DIN;
      if (wr_pending) begin
         write_cnt++;
         if (integ && fifo_m.size() >= 2) ovf_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_write: got unexpected write 0x%0h, none expected", FIFO_DIN);
         end else begin
            check("sb_write", FIFO_DIN, exp_q.pop_front());
         end
      end
      pop_pending = integ && (fifo_m.size() > 0) && (cyc % 3 == 2);
      if (GRANT_VALID && !prev_gv) grant_log.push_back(int'(GRANT_ID));
      prev_gv = GRANT_VALID;
   endtask

   task automatic step();
      @(posedge CLK);
      if (pop_pending) begin
         word_t w;
         w = fifo_m.pop_front();
         pop_cnt++;
         if (pop_exp.size() > 0) check("fifo_pop", w, pop_exp.pop_front());
         else begin
            n_checks++;
            n_fail++;
            $display("FAIL fifo_pop: got extra item 0x%0h, none expected", w);
         end
      end
      if (wr_pending && integ) fifo_m.push_back(wr_din);
      #1;
      for (int i = 0; i < RC; i++)
         if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      drive();
      @(negedge CLK);
      sample();
      cyc++;
   endtask

   function automatic logic pending();
      logic p;
      p = (exp_q.size() > 0) || BUSY;
      for (int i = 0; i < RC; i++) if (rq[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         step();
         n++;
      end
      check({name, "_drained"}, 64'(n < budget), 64'd1);
   endtask

   task automatic do_reset(input logic check_vals);
      nCLR = 1'b0;
      for (int i = 0; i < RC; i++) rq[i].delete();
      exp_q.delete(); pop_exp.delete(); fifo_m.delete(); grant_log.delete();
      full_force = 1'b0; integ = 1'b0; acc = '0;
      wr_pending = 1'b0; pop_pending = 1'b0; prev_gv = 1'b0;
      write_cnt = 0; pop_cnt = 0; ovf_cnt = 0;
      drive();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      if (check_vals) begin
         check("rst_grant_valid", 64'(GRANT_VALID), 64'd0);
         check("rst_grant_id",    64'(GRANT_ID),    64'd0);
         check("rst_req_ready",   64'(REQ_READY),   64'd0);
         check("rst_nwe",         64'(FIFO_nWE),    64'd1);
         check("rst_din",         64'(FIFO_DIN),    64'd0);
         check("rst_busy",        64'(BUSY),        64'd0);
      end
      nCLR = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arb_vec_t tbl[7];
      int n;
      tbl[0] = '{prev: 0, mask: 4'b1111, win: 1};
      tbl[1] = '{prev: 3, mask: 4'b1111, win: 0};
      tbl[2] = '{prev: 1, mask: 4'b0001, win: 0};
      tbl[3] = '{prev: 2, mask: 4'b0100, win: 2};
      tbl[4] = '{prev: 0, mask: 4'b1001, win: 3};
      tbl[5] = '{prev: 3, mask: 4'b0110, win: 1};
      tbl[6] = '{prev: 1, mask: 4'b0011, win: 0};

      #2;
      do_reset(1'b1);

      // Single burst from requester 2
      for (int k = 0; k < 3; k++) begin
         rq[2].push_back({k == 2, 32'hA0 + 32'(k)});
         exp_q.push_back(mk(2, 'hA0 + k));
      end
      step();
      check("sb_idle_gv",    64'(GRANT_VALID), 64'd0);
      check("sb_idle_ready", 64'(REQ_READY),   64'd0);
      step();
      check("sb_grant_valid", 64'(GRANT_VALID), 64'd1);
      check("sb_grant_id",    64'(GRANT_ID),    64'd2);
      check("sb_ready",       64'(REQ_READY),   64'b0100);
      for (int k = 0; k < 3; k++) begin
         step();
         check("sb_nwe_low", 64'(FIFO_nWE), 64'd0);
      end
      check("sb_release_gv", 64'(GRANT_VALID), 64'd0);
      step();
      check("sb_busy_end", 64'(BUSY), 64'd0);
      check("sb_all_written", 64'(exp_q.size()), 64'd0);

      // Round robin, single-beat bursts, requester 0 comes back after releasing
      do_reset(1'b0);
      for (int i = 0; i < RC; i++) begin
         rq[i].push_back({1'b1, 32'h10 * 32'(i)});
         exp_q.push_back(mk(i, 'h10 * i));
      end
      rq[0].push_back({1'b1, 32'h0});
      exp_q.push_back(mk(0, 0));
      wait_drain("rr", 100);
      check("rr_grants", 64'(grant_log.size()), 64'd5);
      for (int k = 0; k < 5 && k < grant_log.size(); k++)
         check("rr_grant_order", 64'(grant_log[k]), 64'(k % 4));

      // Table of arbitration cases: last releaser, valid mask, expected winner
      for (int t = 0; t < 7; t++) begin
         rq[tbl[t].prev].push_back({1'b1, 32'h100 + 32'(tbl[t].prev)});
         exp_q.push_back(mk(tbl[t].prev, 'h100 + tbl[t].prev));
         wait_drain("arb_prev", 40);
         for (int i = 0; i < RC; i++)
            if (tbl[t].mask[i]) rq[i].push_back({1'b1, 32'h200 + 32'(i)});
         exp_q.push_back(mk(tbl[t].win, 'h200 + tbl[t].win));
         step();
         step();
         check("arb_grant_id", 64'(GRANT_ID), 64'(tbl[t].win));
         for (int i = 0; i < RC; i++)
            if (i != tbl[t].win) rq[i].delete();
         wait_drain("arb_win", 40);
      end

      // MAX_BURST cut: requester 1 never sends LAST
      do_reset(1'b0);
      for (int k = 0; k < 12; k++) rq[1].push_back({1'b0, 32'h300 + 32'(k)});
      rq[3].push_back({1'b1, 32'h3F});
      for (int k = 0; k < 8; k++) exp_q.push_back(mk(1, 'h300 + k));
      exp_q.push_back(mk(3, 'h3F));
      for (int k = 8; k < 12; k++) exp_q.push_back(mk(1, 'h300 + k));
      n = 0;
      while ((exp_q.size() > 0 || rq[1].size() > 0) && n < 80) begin
         step();
         n++;
      end
      check("mb_done", 64'(n < 80), 64'd1);
      repeat (3) step();
      check("mb_hold_gv",  64'(GRANT_VALID), 64'd1);
      check("mb_hold_id",  64'(GRANT_ID),    64'd1);
      check("mb_hold_nwe", 64'(FIFO_nWE),    64'd1);
      check("mb_grants",   64'(grant_log.size()), 64'd3);
      if (grant_log.size() == 3) begin
         check("mb_grant0", 64'(grant_log[0]), 64'd1);
         check("mb_grant1", 64'(grant_log[1]), 64'd3);
         check("mb_grant2", 64'(grant_log[2]), 64'd1);
      end

      // Backpressure mid-burst of requester 0
      do_reset(1'b0);
      for (int k = 0; k < 10; k++) begin
         rq[0].push_back({k == 9, 32'(k)});
         exp_q.push_back(mk(0, k));
      end
      n = 0;
      while (write_cnt < 3 && n < 20) begin
         step();
         n++;
      end
      check("bp_started", 64'(n < 20), 64'd1);
      full_force = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_nwe",   64'(FIFO_nWE),     64'd1);
         check("bp_ready", 64'(REQ_READY[0]), 64'd0);
         check("bp_din",   64'(FIFO_DIN),     64'(exp_q[0]));
      end
      full_force = 1'b0;
      wait_drain("bp", 60);
      check("bp_count", 64'(write_cnt), 64'd10);

      // Reset while requester 2 has a beat in the output stage
      do_reset(1'b0);
      for (int k = 0; k < 6; k++) begin
         rq[2].push_back({k == 5, 32'h700 + 32'(k)});
         exp_q.push_back(mk(2, 'h700 + k));
      end
      n = 0;
      while (!(GRANT_VALID && GRANT_ID == 2 && write_cnt >= 2 && !FIFO_nWE) && n < 20) begin
         step();
         n++;
      end
      check("mr_reached", 64'(n < 20), 64'd1);
      #1 nCLR = 1'b0;
      #1;
      check("mr_gv",    64'(GRANT_VALID), 64'd0);
      check("mr_gid",   64'(GRANT_ID),    64'd0);
      check("mr_nwe",   64'(FIFO_nWE),    64'd1);
      check("mr_din",   64'(FIFO_DIN),    64'd0);
      check("mr_busy",  64'(BUSY),        64'd0);
      check("mr_ready", 64'(REQ_READY),   64'd0);
      do_reset(1'b0);
      for (int i = 0; i < RC; i++) begin
         rq[i].push_back({1'b1, 32'h800 + 32'(i)});
         exp_q.push_back(mk(i, 'h800 + i));
      end
      wait_drain("mr_after", 60);
      check("mr_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

      // Integration with a two-entry FiFo model and sparse pops
      do_reset(1'b0);
      integ = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rq[0].push_back({k == 3, 32'h500 + 32'(k)});
         rq[1].push_back({k == 3, 32'h600 + 32'(k)});
      end
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(mk(0, 'h500 + k));
         pop_exp.push_back(mk(0, 'h500 + k));
      end
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(mk(1, 'h600 + k));
         pop_exp.push_back(mk(1, 'h600 + k));
      end
      n = 0;
      while (pop_cnt < 8 && n < 300) begin
         step();
         n++;
      end
      check("it_pops",     64'(pop_cnt),       64'd8);
      check("it_overflow", 64'(ovf_cnt),       64'd0);
      check("it_empty",    64'(fifo_m.size()), 64'd0);
      check("it_busy",     64'(BUSY),          64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the push port of one library FiFo among REQ_COUNT requesters.
- Round-robin arbitration with burst locking: a granted requester keeps the FiFo until it sends its LAST beat or MAX_BURST beats.
- Each accepted beat is tagged with the requester ID and pushed through a one-entry registered output stage that talks directly to the FiFo's nWE/DIN/FULL pins.
- Sits between the producer blocks and the FiFo instance; the FiFo pop side is untouched.

Parameters:
REQ_COUNT, 4, number of requesters (2..16)
DATA_WIDTH, 32, payload width per beat
MAX_BURST, 8, maximum beats per grant before forced release (1..256)
ID_WIDTH, derived localparam = max(1, clog2(REQ_COUNT)), tag width

Ports:
CLK  in  1  clock, all logic on rising edge
nCLR  in  1  reset, asynchronous, active-low
REQ_VALID  in  REQ_COUNT  per-requester beat valid
REQ_LAST  in  REQ_COUNT  per-requester last beat of burst
REQ_DATA  in  REQ_COUNT*DATA_WIDTH  requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
REQ_READY  out  REQ_COUNT  per-requester beat accepted this cycle
FIFO_nWE  out  1  FiFo write enable, active-low
FIFO_DIN  out  ID_WIDTH+DATA_WIDTH  {id, data} to FiFo
FIFO_FULL  in  1  FiFo full flag
GRANT_VALID  out  1  a requester currently holds the grant
GRANT_ID  out  ID_WIDTH  current grantee
BUSY  out  1  grant held or output stage occupied

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (nCLR).
- Reset values:
  - state = IDLE, GRANT_VALID = 0, GRANT_ID = 0, REQ_READY = 0.
  - Output stage empty (out_valid = 0), FIFO_nWE = 1, FIFO_DIN = 0, BUSY = 0.
  - Round-robin pointer last_id = REQ_COUNT-1, so requester 0 has first priority.
  - Beat counter = 0.
- Reset mid-operation: any beat held in the output stage is discarded; no write is issued.
- FSM IDLE:
  - If any REQ_VALID is set, pick the first valid index searching last_id+1, last_id+2, ... (mod REQ_COUNT).
  - Register the winner into GRANT_ID, set GRANT_VALID, clear the beat counter, go to LOCK.
  - Arbitration costs exactly one cycle. REQ_READY is all 0 in IDLE.
- FSM LOCK:
  - can_load = ~out_valid | ~FIFO_FULL.
  - REQ_READY[GRANT_ID] = REQ_VALID[GRANT_ID] & can_load (combinational). All other REQ_READY bits are 0.
  - A beat is accepted when REQ_VALID & REQ_READY for the grantee.
  - On an accepted beat: load the output stage with {GRANT_ID, data}, set out_valid, increment the beat counter.
  - Release when the accepted beat has LAST set, or the beat counter reaches MAX_BURST (i.e. the MAX_BURST-th beat).
  - On release: next state IDLE, last_id <= GRANT_ID, GRANT_VALID <= 0.
  - Grantee drops VALID without LAST: grant is held, no timeout.
- Output stage:
  - FIFO_nWE = ~(out_valid & ~FIFO_FULL), combinational.
  - The stage drains on the cycle FIFO_nWE is low. The same cycle it may reload (full throughput, one beat per cycle).
  - If drained with no new beat, out_valid <= 0.
  - FIFO_FULL held high: the beat stays, REQ_READY stays 0, and the grant stays locked.
  - FIFO_DIN is stable while out_valid is set and not draining.
- Latency: a beat accepted in cycle t appears on FIFO_DIN with FIFO_nWE low at t+1, if not FULL.
- Throughput: one arbitration bubble per burst.
- Fairness: a requester that releases becomes lowest priority. A lone requester is re-granted after one IDLE cycle.
- Simultaneous events:
  - Release and a new VALID from the same requester: that requester loses priority to any other valid requester.
  - FULL deasserts in the same cycle as a beat arrives: drain and reload both happen.
- BUSY = GRANT_VALID | out_valid.

Test Plan:
- Single burst: after reset, REQ_VALID[2]=1 with 3 beats 0xA0, 0xA1, 0xA2 (LAST on 0xA2).
  - GRANT_ID=2 one cycle after VALID.
  - FIFO_DIN = {2,0xA0}, {2,0xA1}, {2,0xA2} on consecutive cycles with FIFO_nWE=0.
  - Back to IDLE; BUSY=0 after the last write.
- Round-robin: all 4 requesters valid, single-beat bursts (LAST=1), data = 0x10*i.
  - Grant order 0,1,2,3,0.
  - FiFo receives tags 0,1,2,3,0.
- MAX_BURST cut: requester 1 streams 12 beats with LAST never set, MAX_BURST=8, requester 3 also valid.
  - 8 beats from 1, then a grant to 3.
  - Requester 1 is re-granted only after 3 releases.
- Backpressure: FIFO_FULL=1 for 5 cycles mid-burst of requester 0.
  - Output stage holds the same {0,data}, FIFO_nWE=1, REQ_READY[0]=0.
  - After FULL drops, beats resume with no loss or duplication; the scoreboard matches data 0..N-1 in order.
- Reset mid-burst: pull nCLR low while requester 2 is granted with a beat in the output stage.
  - All outputs return to reset values immediately.
  - After release, requester 0 wins first with all valid.
- Integration with FiFo (FIFO_DEPTH=2): requesters 0 and 1 each send 4 beats with sparse pops.
  - FiFo never overflows.
  - Popped sequence is exactly 4 tagged beats of 0 followed by 4 of 1.
